// File: rtl/result_vote_filter.sv
// -----------------------------------------------------------------------------
// result_vote_filter
//   Decision stage behind the ShuffleNet classifier. It takes one binary
//   result per inference pass, on the cycle the stage counter enters
//   FINAL_STAGE. The last WINDOW results are kept, and a majority vote with
//   hysteresis (ON_TH / OFF_TH) produces a stable detect level. If no pass
//   arrives for TIMEOUT_CYC cycles, all history is flushed.
//
// Optional feature (macro RESULT_VOTE_HOLD_EN):
//   When detect asserts, it stays high for at least HOLD_EVENTS further
//   events before the thresholds are allowed to clear it.
//
// Ports
//   clk_25          in   25 MHz system clock
//   RST_N           in   asynchronous active-low reset
//   i_stage[5:0]    in   inference stage counter from the classifier
//   i_result        in   classifier output bit, valid while stage==FINAL_STAGE
//   i_result_ready  in   classifier ready; an entry with this low is dropped
//   o_detect        out  filtered detection level (high only in DETECTED)
//   o_detect_rise   out  one-cycle pulse on each 0->1 edge of o_detect
//   o_vote_cnt      out  number of 1s in the valid part of the window
//   o_fill_cnt      out  results held in the window, saturating at WINDOW
//   o_state[1:0]    out  0 FILLING, 1 ARMED, 2 DETECTED
// -----------------------------------------------------------------------------
module result_vote_filter #(
  parameter int WINDOW      = 8,
  parameter int CNT_W       = 5,
  parameter int ON_TH       = 6,
  parameter int OFF_TH      = 2,
  parameter int FINAL_STAGE = 38,
  parameter int TIMEOUT_CYC = 25000000,
  parameter int HOLD_EVENTS = 4
) (
  input  logic             clk_25,
  input  logic             RST_N,
  input  logic [5:0]       i_stage,
  input  logic             i_result,
  input  logic             i_result_ready,
  output logic             o_detect,
  output logic             o_detect_rise,
  output logic [CNT_W-1:0] o_vote_cnt,
  output logic [CNT_W-1:0] o_fill_cnt,
  output logic [1:0]       o_state
);

  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {
    S_FILLING  = 2'd0,
    S_ARMED    = 2'd1,
    S_DETECTED = 2'd2
  } state_t;

  logic [WINDOW-1:0] r_win;
  logic [CNT_W-1:0]  r_vote;
  logic [CNT_W-1:0]  r_fill;
  logic [TO_W-1:0]   r_to;
  logic [5:0]        r_stage_prev;
  logic              r_detect_q;
  state_t            r_state;
  state_t            w_state_nxt;

  logic w_event;
  logic w_full;
  logic w_out;
  logic w_flush;
  logic w_hold_active;

  // One event per entry into FINAL_STAGE. If ready is low on the entry
  // cycle, that pass is dropped. It is not retried later in the same stage.
  assign w_event = (i_stage == 6'(FINAL_STAGE)) &&
                   (r_stage_prev != 6'(FINAL_STAGE)) && i_result_ready;

  assign w_full  = (r_fill == CNT_W'(WINDOW));
  // The bit that shifts out only counts once the window is full. Before
  // that, the top bit is still the zero left by reset or a flush.
  assign w_out   = r_win[WINDOW-1] & w_full;
  // The flush happens on the edge where the counter would reach
  // TIMEOUT_CYC. If an event lands on that edge, the event takes priority.
  assign w_flush = (r_to == TO_W'(TIMEOUT_CYC - 1)) && !w_event;

  always_ff @(posedge clk_25 or negedge RST_N) begin
    if (!RST_N) begin
      r_stage_prev <= '0;
      r_win        <= '0;
      r_vote       <= '0;
      r_fill       <= '0;
      r_to         <= '0;
    end else begin
      r_stage_prev <= i_stage;
      if (w_event) begin
        r_win  <= {r_win[WINDOW-2:0], i_result};
        // Incremental update: vote count = popcount of the valid window bits.
        r_vote <= r_vote + CNT_W'(i_result) - CNT_W'(w_out);
        if (!w_full) r_fill <= r_fill + CNT_W'(1);
        r_to   <= '0;
      end else begin
        if (r_to != TO_W'(TIMEOUT_CYC)) r_to <= r_to + TO_W'(1);
        if (w_flush) begin
          r_win  <= '0;
          r_vote <= '0;
          r_fill <= '0;
        end
      end
    end
  end

`ifdef RESULT_VOTE_HOLD_EN
  localparam int HW = $clog2(HOLD_EVENTS + 1);
  logic [HW-1:0] r_hold;

  assign w_hold_active = (r_hold != '0);

  always_ff @(posedge clk_25 or negedge RST_N) begin
    if (!RST_N)
      r_hold <= '0;
    else if (w_flush)
      r_hold <= '0;
    else if (w_state_nxt == S_DETECTED && r_state != S_DETECTED)
      r_hold <= HW'(HOLD_EVENTS);
    else if (w_event && w_hold_active)
      r_hold <= r_hold - HW'(1);
  end
`else
  assign w_hold_active = 1'b0;
`endif

  // FSM state register. It reads the registered counts, so the state lags
  // the window update by one cycle.
  always_ff @(posedge clk_25 or negedge RST_N) begin
    if (!RST_N) r_state <= S_FILLING;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    if (w_flush) begin
      w_state_nxt = S_FILLING;
    end else begin
      case (r_state)
        S_FILLING:
          if (w_full)
            w_state_nxt = (r_vote >= CNT_W'(ON_TH)) ? S_DETECTED : S_ARMED;
        S_ARMED:
          if (r_vote >= CNT_W'(ON_TH)) w_state_nxt = S_DETECTED;
        S_DETECTED:
          if (r_vote <= CNT_W'(OFF_TH) && !w_hold_active) w_state_nxt = S_ARMED;
        default:
          w_state_nxt = S_FILLING;
      endcase
    end
  end

  // Keep the previous detect level so the rising edge can be found.
  always_ff @(posedge clk_25 or negedge RST_N) begin
    if (!RST_N) r_detect_q <= 1'b0;
    else        r_detect_q <= o_detect;
  end

  // Output logic.
  always_comb begin
    o_detect      = (r_state == S_DETECTED);
    o_detect_rise = o_detect & ~r_detect_q;
    o_state       = r_state;
    o_vote_cnt    = r_vote;
    o_fill_cnt    = r_fill;
  end

endmodule

// File: tb/tb_result_vote_filter.sv
module tb_result_vote_filter;

  logic       clk_25 = 1'b0;
  logic       RST_N  = 1'b0;
  logic [5:0] stage  = '0;
  logic       result = 1'b0;
  logic       result_ready = 1'b0;
  logic       detect, detect_rise;
  logic [4:0] vote_cnt, fill_cnt;
  logic [1:0] state;

  result_vote_filter #(
    .WINDOW(8), .CNT_W(5), .ON_TH(6), .OFF_TH(2),
    .FINAL_STAGE(38), .TIMEOUT_CYC(100), .HOLD_EVENTS(4)
  ) dut (
    .clk_25(clk_25), .RST_N(RST_N),
    .i_stage(stage), .i_result(result), .i_result_ready(result_ready),
    .o_detect(detect), .o_detect_rise(detect_rise),
    .o_vote_cnt(vote_cnt), .o_fill_cnt(fill_cnt), .o_state(state)
  );

  always #20 clk_25 = ~clk_25;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic r;
    logic rdy;
    int   v;
    int   f;
    int   s;
  } vec_t;

  vec_t tbl[23];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int v, input int f, input int s);
    chk({tag, " vote_cnt"}, 32'(vote_cnt), v);
    chk({tag, " fill_cnt"}, 32'(fill_cnt), f);
    chk({tag, " state"},    32'(state),    s);
    chk({tag, " detect"},   32'(detect),   (s == 2) ? 1 : 0);
  endtask

  // n >= 1 rising edges, then return on the following falling edge
  task automatic tick(input int n);
    repeat (n) @(posedge clk_25);
    @(negedge clk_25);
  endtask

  // A single inference pass takes 4 cycles: stage sits at 38 for two
  // cycles, with ready always raised on the second, then drops to 0 for two.
  task automatic do_pass(input logic r, input logic rdy);
    stage = 6'd38; result = r; result_ready = rdy;
    tick(1);
    result_ready = 1'b1;
    tick(1);
    stage = 6'd0; result = 1'b0; result_ready = 1'b0;
    tick(2);
  endtask

  initial begin
    int idx;
    int pat_v[8] = '{2, 1, 2, 2, 3, 3, 4, 4};

    // ---- table: dropped pass, fill with 1s, drain with 0s, 1/0 pattern ----
    tbl[0] = '{1'b1, 1'b0, 0, 0, 0};
    idx = 1;
    for (int k = 1; k <= 8; k++) begin
      tbl[idx] = '{1'b1, 1'b1, k, k, (k == 8) ? 2 : 0};
      idx++;
    end
    for (int k = 7; k >= 2; k--) begin
      tbl[idx] = '{1'b0, 1'b1, k, 8, (k == 2) ? 1 : 2};
      idx++;
    end
    for (int j = 0; j < 8; j++) begin
      tbl[idx] = '{(j % 2 == 0) ? 1'b1 : 1'b0, 1'b1, pat_v[j], 8, 1};
      idx++;
    end

    // ---- reset state ----
    tick(2);
    chk_all("reset", 0, 0, 0);
    chk("reset detect_rise", 32'(detect_rise), 0);
    RST_N = 1'b1;
    tick(2);

    // ---- stage held at 38 for 60 cycles: exactly one event ----
    stage = 6'd38; result = 1'b1; result_ready = 1'b1;
    tick(60);
    chk_all("long hold", 1, 1, 0);

    // ---- asynchronous reset in the middle of operation ----
    #5 RST_N = 1'b0;
    #1 chk("async rst vote_cnt", 32'(vote_cnt), 0);
    chk("async rst fill_cnt", 32'(fill_cnt), 0);
    stage = 6'd0; result = 1'b0; result_ready = 1'b0;
    @(negedge clk_25);
    RST_N = 1'b1;
    tick(2);

    // ---- table-driven passes ----
    for (int i = 0; i < 23; i++) begin
      do_pass(tbl[i].r, tbl[i].rdy);
      chk_all($sformatf("vec%0d", i), tbl[i].v, tbl[i].f, tbl[i].s);
    end

    // ---- 12 more 1/0 pairs: vote stays at 4, never detects ----
    for (int j = 0; j < 12; j++) begin
      do_pass(1'b1, 1'b1);
      chk_all($sformatf("pat1 %0d", j), 4, 8, 1);
      do_pass(1'b0, 1'b1);
      chk_all($sformatf("pat0 %0d", j), 4, 8, 1);
    end

    // ---- timeout boundary from ARMED (3 idle cycles already elapsed) ----
    tick(96);
    chk_all("to-1 armed", 4, 8, 1);
    tick(1);
    chk_all("to armed", 0, 0, 0);

    // ---- refill, and check detect_rise on the 8th pass ----
    for (int k = 1; k <= 7; k++) begin
      do_pass(1'b1, 1'b1);
      chk_all($sformatf("refill%0d", k), k, k, 0);
    end
    stage = 6'd38; result = 1'b1; result_ready = 1'b1;
    tick(1);
    chk_all("8th event", 8, 8, 0);
    chk("8th event rise", 32'(detect_rise), 0);
    stage = 6'd0; result = 1'b0; result_ready = 1'b0;
    tick(1);
    chk("rise cycle detect", 32'(detect), 1);
    chk("rise cycle pulse", 32'(detect_rise), 1);
    tick(1);
    chk("after rise detect", 32'(detect), 1);
    chk("after rise pulse", 32'(detect_rise), 0);

    // ---- an event on the timeout edge wins over the flush ----
    tick(97);
    chk_all("pre-collide", 8, 8, 2);
    stage = 6'd38; result = 1'b0; result_ready = 1'b1;
    tick(1);
    chk("collide vote_cnt", 32'(vote_cnt), 7);
    chk("collide fill_cnt", 32'(fill_cnt), 8);
    stage = 6'd0; result_ready = 1'b0;
    tick(1);
    chk_all("collide settle", 7, 8, 2);

    // ---- timeout from DETECTED ----
    tick(98);
    chk_all("to-1 det", 7, 8, 2);
    tick(1);
    chk_all("to det", 0, 0, 0);
    chk("to det rise", 32'(detect_rise), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
